// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - parametrised prescaler counter with limit reload, hold, one-shot and tick accumulator
module tick_prescaler #(
  parameter int unsigned            WIDTH         = 32,
  parameter logic [WIDTH-1:0]       DEFAULT_LIMIT = WIDTH'(4999999),
  parameter int unsigned            TCNT_W        = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_enable,
  input  logic              i_hold,
  input  logic              i_oneshot,
  input  logic [WIDTH-1:0]  i_limit,
  input  logic              i_limit_wr,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_tick,
  output logic              o_busy,
  output logic              o_done,
  output logic [TCNT_W-1:0] o_tick_count,
  output logic [WIDTH-1:0]  o_limit
);

  // Operating mode is a pure function of the run inputs and the sticky done flag.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } mode_t;

  logic [WIDTH-1:0]  count_q,      count_d;
  logic [TCNT_W-1:0] tick_count_q, tick_count_d;
  logic              done_q,       done_d;
  logic [WIDTH-1:0]  active_q,     active_d;
  logic [WIDTH-1:0]  shadow_q,     shadow_d;
  logic              pending_q,    pending_d;

  mode_t mode;
  logic  adv;
  logic  term;
  logic  apply;

  // Terminal also covers count above limit so a stale count can never run away.
  assign term = (count_q >= active_q);
  assign adv  = i_enable & ~i_hold & ~done_q;

  // Decode the current mode; enable low dominates everything else.
  always_comb begin
    mode = S_IDLE;
    if (!i_enable) begin
      mode = S_IDLE;
    end else if (done_q) begin
      mode = S_DONE;
    end else if (i_hold) begin
      mode = S_HOLD;
    end else begin
      mode = S_RUN;
    end
  end

  // Shadow limit only reaches the active limit at a wrap or while idle, never mid-period.
  always_comb begin
    apply     = pending_q & ((adv & term) | ~i_enable);
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (apply) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (i_limit_wr) begin
      shadow_d  = i_limit;
      pending_d = 1'b1;
    end
  end

  // Next-state for count, accumulator and done flag per mode.
  always_comb begin
    count_d      = count_q;
    tick_count_d = tick_count_q;
    done_d       = done_q;
    case (mode)
      S_IDLE: begin
        count_d      = '0;
        tick_count_d = '0;
        done_d       = 1'b0;
      end
      S_RUN: begin
        if (term) begin
          count_d      = '0;
          tick_count_d = tick_count_q + TCNT_W'(1);
          if (i_oneshot) begin
            done_d = 1'b1;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      S_HOLD: begin
        count_d = count_q;
      end
      S_DONE: begin
        count_d = '0;
      end
      default: begin
        count_d = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset; reset discards any pending write.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_q      <= '0;
      tick_count_q <= '0;
      done_q       <= 1'b0;
      active_q     <= DEFAULT_LIMIT;
      shadow_q     <= DEFAULT_LIMIT;
      pending_q    <= 1'b0;
    end else begin
      count_q      <= count_d;
      tick_count_q <= tick_count_d;
      done_q       <= done_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign o_tick       = i_rstn & adv & term;
  assign o_busy       = i_rstn & i_enable & ~done_q;
  assign o_count      = count_q;
  assign o_done       = done_q;
  assign o_tick_count = tick_count_q;
  assign o_limit      = active_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// tb/tb_tick_prescaler.sv - directed self-checking bench for tick_prescaler
module tb_tick_prescaler;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned TCNT_W = 2;

  logic              i_clk;
  logic              i_rstn;
  logic              i_enable;
  logic              i_hold;
  logic              i_oneshot;
  logic [WIDTH-1:0]  i_limit;
  logic              i_limit_wr;
  logic [WIDTH-1:0]  o_count;
  logic              o_tick;
  logic              o_busy;
  logic              o_done;
  logic [TCNT_W-1:0] o_tick_count;
  logic [WIDTH-1:0]  o_limit;

  int n_cmp;
  int n_bad;

  tick_prescaler #(
    .WIDTH        (WIDTH),
    .DEFAULT_LIMIT(8'd4),
    .TCNT_W       (TCNT_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_enable    (i_enable),
    .i_hold      (i_hold),
    .i_oneshot   (i_oneshot),
    .i_limit     (i_limit),
    .i_limit_wr  (i_limit_wr),
    .o_count     (o_count),
    .o_tick      (o_tick),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_tick_count(o_tick_count),
    .o_limit     (o_limit)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #2;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    i_rstn     = 1'b0;
    i_enable   = 1'b0;
    i_hold     = 1'b0;
    i_oneshot  = 1'b0;
    i_limit    = '0;
    i_limit_wr = 1'b0;
    #12;
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_tick",  32'(o_tick),  32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_done",  32'(o_done),  32'd0);
    chk("rst_tcnt",  32'(o_tick_count), 32'd0);
    chk("rst_limit", 32'(o_limit), 32'd4);

    // 1: default limit 4, period 5
    @(negedge i_clk);
    i_rstn   = 1'b1;
    i_enable = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("t1_count", 32'(o_count), 32'(i % 5));
      chk("t1_tick",  32'(o_tick),  32'((i % 5) == 4));
      cyc();
    end
    chk("t1_tcnt", 32'(o_tick_count), 32'd2);

    // 2: write limit 2 at count 1, applied at the next wrap
    cyc();
    chk("t2_count1", 32'(o_count), 32'd1);
    i_limit    = 8'd2;
    i_limit_wr = 1'b1;
    cyc();
    i_limit_wr = 1'b0;
    chk("t2_count2", 32'(o_count), 32'd2);
    chk("t2_old_limit", 32'(o_limit), 32'd4);
    cyc();
    cyc();
    #1;
    chk("t2_count4", 32'(o_count), 32'd4);
    chk("t2_tick4",  32'(o_tick),  32'd1);
    cyc();
    chk("t2_new_limit", 32'(o_limit), 32'd2);
    for (int i = 0; i < 6; i++) begin
      chk("t2_count", 32'(o_count), 32'(i % 3));
      chk("t2_tick",  32'(o_tick),  32'((i % 3) == 2));
      cyc();
    end
    chk("t2_tcnt_wrap", 32'(o_tick_count), 32'd1);

    // 3: restore limit 4, then hold three cycles at count 3
    i_limit    = 8'd4;
    i_limit_wr = 1'b1;
    cyc();
    i_limit_wr = 1'b0;
    cyc();
    cyc();
    chk("t3_limit4", 32'(o_limit), 32'd4);
    chk("t3_tcnt",   32'(o_tick_count), 32'd2);
    cyc();
    cyc();
    cyc();
    i_hold = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t3_hold_count", 32'(o_count), 32'd3);
      chk("t3_hold_tick",  32'(o_tick),  32'd0);
      chk("t3_hold_busy",  32'(o_busy),  32'd1);
      cyc();
    end
    i_hold = 1'b0;
    #1;
    chk("t3_resume3", 32'(o_count), 32'd3);
    cyc();
    chk("t3_count4", 32'(o_count), 32'd4);
    chk("t3_tick4",  32'(o_tick),  32'd1);
    cyc();
    chk("t3_wrap", 32'(o_count), 32'd0);
    chk("t3_tcnt3", 32'(o_tick_count), 32'd3);

    // 4: one-shot at limit 2
    i_limit    = 8'd2;
    i_limit_wr = 1'b1;
    cyc();
    i_limit_wr = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("t4_pre_tick", 32'(o_tick), 32'd1);
    cyc();
    chk("t4_limit2", 32'(o_limit), 32'd2);
    chk("t4_tcnt0",  32'(o_tick_count), 32'd0);
    i_oneshot = 1'b1;
    cyc();
    cyc();
    #1;
    chk("t4_os_tick", 32'(o_tick), 32'd1);
    cyc();
    chk("t4_done",  32'(o_done),  32'd1);
    chk("t4_busy",  32'(o_busy),  32'd0);
    chk("t4_count", 32'(o_count), 32'd0);
    chk("t4_tcnt",  32'(o_tick_count), 32'd1);
    cyc();
    cyc();
    chk("t4_stay_count", 32'(o_count), 32'd0);
    chk("t4_stay_tick",  32'(o_tick),  32'd0);
    chk("t4_stay_done",  32'(o_done),  32'd1);
    i_enable = 1'b0;
    cyc();
    chk("t4_clr_done", 32'(o_done), 32'd0);
    chk("t4_clr_tcnt", 32'(o_tick_count), 32'd0);
    i_oneshot = 1'b0;
    i_enable  = 1'b1;
    #1;
    chk("t4_busy_again", 32'(o_busy), 32'd1);

    // 5: limit 0 ticks every cycle; 2-bit accumulator wraps
    i_enable   = 1'b0;
    i_limit    = 8'd0;
    i_limit_wr = 1'b1;
    cyc();
    i_limit_wr = 1'b0;
    cyc();
    chk("t5_limit0", 32'(o_limit), 32'd0);
    i_enable = 1'b1;
    #1;
    chk("t5_tick0", 32'(o_tick), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("t5_tcnt",  32'(o_tick_count), 32'(i % 4));
      chk("t5_tick",  32'(o_tick),  32'd1);
      chk("t5_count", 32'(o_count), 32'd0);
    end
    i_enable = 1'b0;
    #1;
    chk("t5_idle_tick", 32'(o_tick), 32'd0);
    cyc();
    chk("t5_idle_tcnt", 32'(o_tick_count), 32'd0);

    // 6: async reset mid-count discards pending write
    i_limit    = 8'd4;
    i_limit_wr = 1'b1;
    cyc();
    i_limit_wr = 1'b0;
    cyc();
    i_enable = 1'b1;
    cyc();
    cyc();
    i_limit    = 8'd1;
    i_limit_wr = 1'b1;
    cyc();
    i_limit_wr = 1'b0;
    chk("t6_pre_count", 32'(o_count), 32'd3);
    #1;
    i_rstn = 1'b0;
    #1;
    chk("t6_rst_count", 32'(o_count), 32'd0);
    chk("t6_rst_limit", 32'(o_limit), 32'd4);
    chk("t6_rst_busy",  32'(o_busy),  32'd0);
    chk("t6_rst_tick",  32'(o_tick),  32'd0);
    chk("t6_rst_tcnt",  32'(o_tick_count), 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    cyc();
    cyc();
    cyc();
    cyc();
    cyc();
    chk("t6_wrap_count", 32'(o_count), 32'd0);
    chk("t6_keep_limit", 32'(o_limit), 32'd4);
    chk("t6_tcnt",       32'(o_tick_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
